vm_ctrl_fsm: RTL and testbench

//  Command sequencer for the vending-machine datapath (dp). Turns front-panel keys into the 2-bit dp command stream.

---
 rtl/vm_ctrl_fsm_pkg.sv | 51 +++++
 rtl/vm_ctrl_fsm_if.sv | 28 ++
 rtl/vm_ctrl_fsm_idle_timer.sv | 28 ++
 rtl/vm_ctrl_fsm.sv | 127 ++++++++++++
 tb/tb_vm_ctrl_fsm.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/vm_ctrl_fsm_pkg.sv
// Shared types and constants for the vending-machine command sequencer.
// Holds the dp command codes, the FSM state codes, item prices and money units.
package vm_ctrl_fsm_pkg;

  localparam int unsigned CMD_W   = 2;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned SEL_W   = 4;
  localparam int unsigned MONEY_W = 16;

  // Money is counted in eighths of a dollar.
  localparam int unsigned MONEY_UNITS_PER_DOLLAR = 8;
  localparam int unsigned ITEM_PRICE_A = 14;
  localparam int unsigned ITEM_PRICE_B = 12;
  localparam int unsigned ITEM_PRICE_C = 10;
  localparam int unsigned ITEM_PRICE_D = 8;

  typedef enum logic [CMD_W-1:0] {
    CMD_SITEM  = 2'b00,
    CMD_SMONEY = 2'b01,
    CMD_CLEAR  = 2'b10,
    CMD_START  = 2'b11
  } dp_cmd_e;

  typedef enum logic [STATE_W-1:0] {
    ST_INIT      = 3'd0,
    ST_COLLECT   = 3'd1,
    ST_VEND_ALL  = 3'd2,
    ST_VEND_KEEP = 3'd3,
    ST_REFUND    = 3'd4,
    ST_HOLD      = 3'd5
  } vm_state_e;

  typedef struct packed {
    logic buy;
    logic more;
    logic cancel;
  } key_t;

  // Command the dp must see while the FSM sits in a given state.
  function automatic dp_cmd_e cmd_of_state(input vm_state_e s);
    case (s)
      ST_COLLECT:   return CMD_START;
      ST_VEND_ALL:  return CMD_SMONEY;
      ST_REFUND:    return CMD_SMONEY;
      ST_VEND_KEEP: return CMD_SITEM;
      ST_HOLD:      return CMD_SITEM;
      default:      return CMD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/vm_ctrl_fsm_if.sv
// Panel/dp-facing signal bundle of the command sequencer.
// The master side drives keys and dp status; the slave side (the FSM) drives command and flags.
interface vm_ctrl_fsm_if;
  import vm_ctrl_fsm_pkg::*;

  logic                 in_key_buy;
  logic                 in_key_more;
  logic                 in_key_cancel;
  logic                 in_activity;
  logic [SEL_W-1:0]     in_csel;
  logic [MONEY_W-1:0]   in_change;
  logic [CMD_W-1:0]     out_cmd;
  logic [STATE_W-1:0]   out_state;
  logic                 out_busy;
  logic                 out_short;
  logic                 out_reject;

  modport master (
    output in_key_buy, in_key_more, in_key_cancel, in_activity, in_csel, in_change,
    input  out_cmd, out_state, out_busy, out_short, out_reject
  );

  modport slave (
    input  in_key_buy, in_key_more, in_key_cancel, in_activity, in_csel, in_change,
    output out_cmd, out_state, out_busy, out_short, out_reject
  );

endinterface

// File: rtl/vm_ctrl_fsm_idle_timer.sv
// Clear/enable up-counter saturating at a run-time limit.
// expire_c flags the cycle whose increment reaches the limit.
module vm_ctrl_fsm_idle_timer #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expire_c
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != limit)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expire_c = en && (cnt == (limit - W'(1)));

endmodule

// File: rtl/vm_ctrl_fsm.sv
// Vending-machine command sequencer: panel keys in, 2-bit dp command stream out.
// Outputs are registered from the next state so command and state change on the same edge.
module vm_ctrl_fsm
  import vm_ctrl_fsm_pkg::*;
#(
  parameter int unsigned CLEAR_CYC   = 2,
  parameter int unsigned HOLD_CYC    = 4,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input logic          in_clka,
  input logic          in_restart,
  vm_ctrl_fsm_if.slave bus
);

  localparam int unsigned DWELL_MAX = (CLEAR_CYC > HOLD_CYC) ? CLEAR_CYC : HOLD_CYC;
  localparam int unsigned DWELL_W   = $clog2(DWELL_MAX + 1);
  localparam int unsigned IDLE_W    = $clog2(TIMEOUT_CYC + 1);

  vm_state_e state_q, state_d;

  key_t   keys;
  logic   any_key, in_collect, sel_none, chg_neg, chg_zero, buy_ok, more_ok;
  logic   dwell_en, dwell_clr, dwell_exp_c;
  logic   [DWELL_W-1:0] dwell_limit;
  logic   idle_en, idle_clr, idle_exp_c, idle_timeout;

  dp_cmd_e cmd_c;
  logic    busy_c, short_c, reject_c;

  // Purchase qualifiers use only the sign bit and a zero test of the dp change.
  assign keys       = '{buy: bus.in_key_buy, more: bus.in_key_more, cancel: bus.in_key_cancel};
  assign any_key    = keys.buy || keys.more || keys.cancel;
  assign in_collect = (state_q == ST_COLLECT);
  assign sel_none   = (bus.in_csel == '0);
  assign chg_neg    = bus.in_change[MONEY_W-1];
  assign chg_zero   = (bus.in_change == '0);
  assign buy_ok     = !sel_none && !chg_neg;
  assign more_ok    = !sel_none && !chg_neg && !chg_zero;

  // One dwell counter serves both INIT and HOLD; it restarts on every state change.
  assign dwell_en    = (state_q == ST_INIT) || (state_q == ST_HOLD);
  assign dwell_clr   = (state_d != state_q);
  assign dwell_limit = (state_q == ST_HOLD) ? DWELL_W'(HOLD_CYC) : DWELL_W'(CLEAR_CYC);

  vm_ctrl_fsm_idle_timer #(.W(DWELL_W)) u_dwell (
    .clk      (in_clka),
    .rst      (in_restart),
    .clr      (dwell_clr),
    .en       (dwell_en),
    .limit    (dwell_limit),
    .expire_c (dwell_exp_c)
  );

  // Idle counter restarts on any panel action and whenever a timeout is not honoured.
  assign idle_en      = in_collect;
  assign idle_clr     = !in_collect || bus.in_activity || any_key || idle_exp_c;
  assign idle_timeout = idle_exp_c && !bus.in_activity && sel_none && !chg_zero;

  vm_ctrl_fsm_idle_timer #(.W(IDLE_W)) u_idle (
    .clk      (in_clka),
    .rst      (in_restart),
    .clr      (idle_clr),
    .en       (idle_en),
    .limit    (IDLE_W'(TIMEOUT_CYC)),
    .expire_c (idle_exp_c)
  );

  // State register plus registered outputs.
  always_ff @(posedge in_clka or posedge in_restart) begin
    if (in_restart) begin
      state_q        <= ST_INIT;
      bus.out_cmd    <= CMD_CLEAR;
      bus.out_state  <= ST_INIT;
      bus.out_busy   <= 1'b1;
      bus.out_short  <= 1'b0;
      bus.out_reject <= 1'b0;
    end else begin
      state_q        <= state_d;
      bus.out_cmd    <= cmd_c;
      bus.out_state  <= state_d;
      bus.out_busy   <= busy_c;
      bus.out_short  <= short_c;
      bus.out_reject <= reject_c;
    end
  end

  // Next-state logic; in COLLECT the priority is cancel > buy > more > timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: begin
        if (dwell_exp_c) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (keys.cancel) begin
          if (sel_none) state_d = ST_REFUND;
        end else if (keys.buy) begin
          if (buy_ok) state_d = ST_VEND_ALL;
        end else if (keys.more) begin
          if (more_ok) state_d = ST_VEND_KEEP;
        end else if (idle_timeout) begin
          state_d = ST_REFUND;
        end
      end
      ST_VEND_ALL:  state_d = ST_HOLD;
      ST_REFUND:    state_d = ST_HOLD;
      ST_VEND_KEEP: state_d = ST_COLLECT;
      ST_HOLD: begin
        if (dwell_exp_c) state_d = ST_COLLECT;
      end
      default:      state_d = ST_INIT;
    endcase
  end

  // Output logic; refusal pulses only fire on cycles where the state holds.
  always_comb begin
    cmd_c    = cmd_of_state(state_d);
    busy_c   = (state_d != ST_COLLECT);
    short_c  = 1'b0;
    reject_c = 1'b0;
    if (in_collect) begin
      reject_c = keys.cancel && !sel_none;
      short_c  = !keys.cancel && ((keys.buy && !buy_ok) || (!keys.buy && keys.more && !more_ok));
    end
  end

endmodule

// File: tb/tb_vm_ctrl_fsm.sv
// Scoreboard bench for vm_ctrl_fsm: stimulus queues expected per-cycle outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_vm_ctrl_fsm;

  localparam logic [2:0] S_INIT = 3'd0, S_COLLECT = 3'd1, S_VEND_ALL = 3'd2,
                         S_VEND_KEEP = 3'd3, S_REFUND = 3'd4, S_HOLD = 3'd5;
  localparam logic [2:0] K_NONE = 3'b000, K_MORE = 3'b001, K_BUY = 3'b010, K_CANCEL = 3'b100;

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] cmd;
    logic       busy;
    logic       sh;
    logic       rj;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  vm_ctrl_fsm_if bus();

  vm_ctrl_fsm #(
    .CLEAR_CYC   (2),
    .HOLD_CYC    (4),
    .TIMEOUT_CYC (10)
  ) dut (
    .in_clka    (clk),
    .in_restart (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] exp_cmd(input logic [2:0] st);
    case (st)
      S_INIT:      return 2'b10;
      S_COLLECT:   return 2'b11;
      S_VEND_ALL:  return 2'b01;
      S_VEND_KEEP: return 2'b00;
      S_REFUND:    return 2'b01;
      S_HOLD:      return 2'b00;
      default:     return 2'b10;
    endcase
  endfunction

  task automatic push(input string tag, input logic [2:0] st, input logic sh, input logic rj);
    obs_t e;
    e.st   = st;
    e.cmd  = exp_cmd(st);
    e.busy = (st != S_COLLECT);
    e.sh   = sh;
    e.rj   = rj;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // One clock of stimulus: key pulses/activity for this cycle, then expected outputs after the edge.
  task automatic cyc(input string tag, input logic [2:0] k, input logic act,
                     input logic [2:0] st, input logic sh, input logic rj);
    bus.in_key_cancel = k[2];
    bus.in_key_buy    = k[1];
    bus.in_key_more   = k[0];
    bus.in_activity   = act;
    @(posedge clk);
    #1;
    bus.in_key_cancel = 1'b0;
    bus.in_key_buy    = 1'b0;
    bus.in_key_more   = 1'b0;
    bus.in_activity   = 1'b0;
    push(tag, st, sh, rj);
  endtask

  task automatic hold_then_collect(input string tag);
    repeat (4) cyc(tag, K_NONE, 1'b0, S_HOLD, 1'b0, 1'b0);
    cyc(tag, K_NONE, 1'b0, S_COLLECT, 1'b0, 1'b0);
  endtask

  task automatic set_dp(input logic [3:0] csel, input logic [15:0] chg);
    bus.in_csel   = csel;
    bus.in_change = chg;
  endtask

  // Monitor: compare the DUT against the oldest expectation, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t  e;
      obs_t  a;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {bus.out_state, bus.out_cmd, bus.out_busy, bus.out_short, bus.out_reject};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got state=%0d cmd=%0d busy=%0b short=%0b reject=%0b, want state=%0d cmd=%0d busy=%0b short=%0b reject=%0b",
                 t, a.st, a.cmd, a.busy, a.sh, a.rj, e.st, e.cmd, e.busy, e.sh, e.rj);
      end
    end
  end

  initial begin
    bus.in_key_buy    = 1'b0;
    bus.in_key_more   = 1'b0;
    bus.in_key_cancel = 1'b0;
    bus.in_activity   = 1'b0;
    set_dp(4'b0000, 16'h0000);

    repeat (2) @(posedge clk);
    #1;
    push("reset", S_INIT, 1'b0, 1'b0);
    rst = 1'b0;
    cyc("init_clear", K_NONE, 1'b0, S_INIT, 1'b0, 1'b0);
    cyc("init_done", K_NONE, 1'b0, S_COLLECT, 1'b0, 1'b0);

    // Final purchase, with a buy key during HOLD that must be dropped.
    set_dp(4'b0001, 16'h0002);
    cyc("buy_ok", K_BUY, 1'b0, S_VEND_ALL, 1'b0, 1'b0);
    cyc("buy_hold", K_NONE, 1'b0, S_HOLD, 1'b0, 1'b0);
    cyc("buy_hold_key", K_BUY, 1'b0, S_HOLD, 1'b0, 1'b0);
    cyc("buy_hold", K_NONE, 1'b0, S_HOLD, 1'b0, 1'b0);
    cyc("buy_hold", K_NONE, 1'b0, S_HOLD, 1'b0, 1'b0);
    cyc("buy_back", K_NONE, 1'b0, S_COLLECT, 1'b0, 1'b0);

    // Refused purchases.
    set_dp(4'b0010, 16'hFFFC);
    cyc("buy_short", K_BUY, 1'b0, S_COLLECT, 1'b1, 1'b0);
    cyc("short_clr", K_NONE, 1'b0, S_COLLECT, 1'b0, 1'b0);
    cyc("more_neg", K_MORE, 1'b0, S_COLLECT, 1'b1, 1'b0);
    set_dp(4'b0010, 16'h0000);
    cyc("more_zero", K_MORE, 1'b0, S_COLLECT, 1'b1, 1'b0);
    set_dp(4'b0010, 16'h0001);
    cyc("more_ok", K_MORE, 1'b0, S_VEND_KEEP, 1'b0, 1'b0);
    cyc("more_back", K_NONE, 1'b0, S_COLLECT, 1'b0, 1'b0);
    set_dp(4'b0000, 16'h0002);
    cyc("buy_nosel", K_BUY, 1'b0, S_COLLECT, 1'b1, 1'b0);
    set_dp(4'b0010, 16'h0000);
    cyc("buy_exact", K_BUY, 1'b0, S_VEND_ALL, 1'b0, 1'b0);
    hold_then_collect("buy_exact_hold");

    // Cancel handling and priority.
    set_dp(4'b0100, 16'h0008);
    cyc("cancel_rej", K_CANCEL, 1'b0, S_COLLECT, 1'b0, 1'b1);
    set_dp(4'b0001, 16'h0002);
    cyc("cancel_buy_rej", K_CANCEL | K_BUY, 1'b0, S_COLLECT, 1'b0, 1'b1);
    set_dp(4'b0000, 16'h0008);
    cyc("cancel_ok", K_CANCEL, 1'b0, S_REFUND, 1'b0, 1'b0);
    hold_then_collect("cancel_hold");
    cyc("cancel_buy_ok", K_CANCEL | K_BUY, 1'b0, S_REFUND, 1'b0, 1'b0);
    hold_then_collect("cancel_buy_hold");

    // Idle timeout refund after 10 quiet COLLECT cycles.
    for (int i = 0; i < 9; i++) cyc("idle_wait", K_NONE, 1'b0, S_COLLECT, 1'b0, 1'b0);
    cyc("idle_refund", K_NONE, 1'b0, S_REFUND, 1'b0, 1'b0);
    hold_then_collect("idle_hold");

    // Activity on the 9th idle cycle restarts the count.
    for (int i = 0; i < 9; i++) cyc("act_wait", K_NONE, (i == 8), S_COLLECT, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cyc("act_wait2", K_NONE, 1'b0, S_COLLECT, 1'b0, 1'b0);
    cyc("act_refund", K_NONE, 1'b0, S_REFUND, 1'b0, 1'b0);
    hold_then_collect("act_hold");

    // Timeout with an active selection is not honoured.
    set_dp(4'b0001, 16'h0008);
    for (int i = 0; i < 12; i++) cyc("idle_sel", K_NONE, 1'b0, S_COLLECT, 1'b0, 1'b0);

    // Restart asserted mid-cycle during HOLD takes effect without a clock edge.
    set_dp(4'b0000, 16'h0008);
    cyc("pre_rst_refund", K_CANCEL, 1'b0, S_REFUND, 1'b0, 1'b0);
    cyc("pre_rst_hold", K_NONE, 1'b0, S_HOLD, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    push("async_rst", S_INIT, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    cyc("rst_init", K_NONE, 1'b0, S_INIT, 1'b0, 1'b0);
    cyc("rst_collect", K_NONE, 1'b0, S_COLLECT, 1'b0, 1'b0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
